// File: rtl/micro_phase_seq.sv
// One-hot instruction phase generator for the micro core.
// Supports a configurable phase count, stall, early termination (skip), and halt/resume with a retired-instruction counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | phases advance; instructions complete and retire
// ST_HALT | phase vector is all-zero; waits for resume
module micro_phase_seq #(
    parameter int NPH = 5,
    parameter int CW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hlt,
    input  logic           stall,
    input  logic           skip,
    input  logic           resume,
    output logic [NPH-1:0] phase,
    output logic           halted,
    output logic           last,
    output logic [CW-1:0]  retired
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [NPH-1:0] PH_FETCH = {1'b1, {(NPH-1){1'b0}}};

    state_t         state_q,    state_d;
    logic [NPH-1:0] phase_q,    phase_d;
    logic [CW-1:0]  retired_q,  retired_d;
    logic           hlt_pend_q, hlt_pend_d;
    logic           last_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            phase_q    <= PH_FETCH;
            retired_q  <= '0;
            hlt_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            retired_q  <= retired_d;
            hlt_pend_q <= hlt_pend_d;
        end
    end

    // Instruction completes this cycle; downstream commit logic qualifies on it.
    assign last_c = (state_q == ST_RUN) && !stall && (phase_q[0] || skip);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        retired_d  = retired_q;
        hlt_pend_d = hlt_pend_q;

        unique case (state_q)
            ST_RUN: begin
                if (stall) begin
                    if (hlt) hlt_pend_d = 1'b1;
                end else if (last_c) begin
                    retired_d = retired_q + CW'(1);
                    if (hlt || hlt_pend_q) begin
                        state_d    = ST_HALT;
                        phase_d    = '0;
                        hlt_pend_d = 1'b0;
                    end else begin
                        phase_d = PH_FETCH;
                    end
                end else begin
                    // phase_q[0] implies last_c here, so the shift never empties the vector.
                    phase_d = phase_q >> 1;
                    if (hlt) hlt_pend_d = 1'b1;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                    phase_d = PH_FETCH;
                end
            end
            default: begin
                state_d = ST_RUN;
                phase_d = PH_FETCH;
            end
        endcase
    end

    assign phase   = phase_q;
    assign halted  = (state_q == ST_HALT);
    assign last    = last_c;
    assign retired = retired_q;

endmodule
